// File: rtl/fft_peak_detect_if.sv
// FFT-output bus: one 16-bin frame strobe toward the peak detector,
// plus the detector's result/status signals back toward the consumer.
interface fft_peak_detect_if #(
  parameter int DW = 16
);
  logic            fft_valid;
  logic [2*DW-1:0] fft_d0, fft_d1, fft_d2, fft_d3;
  logic [2*DW-1:0] fft_d4, fft_d5, fft_d6, fft_d7;
  logic [2*DW-1:0] fft_d8, fft_d9, fft_d10, fft_d11;
  logic [2*DW-1:0] fft_d12, fft_d13, fft_d14, fft_d15;
  logic            done;
  logic [3:0]      freq;
  logic [2*DW-1:0] peak_mag;
  logic            busy;
  logic            overrun;

  // Frame producer side: drives bins, observes results
  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, peak_mag, busy, overrun
  );

  // Peak detector side
  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, peak_mag, busy, overrun
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Captures a 16-bin FFT frame, scans one bin per cycle for the largest
// squared magnitude (lowest index wins ties) and reports it with a done pulse.
module fft_peak_detect #(
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_peak_detect_if.slave   bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_reg, state_next;
  logic [2*DW-1:0] bank_reg [16];
  logic [2*DW-1:0] in_words [16];
  logic [3:0]      idx_reg, idx_next;
  logic [2*DW-1:0] max_reg, max_next;
  logic [3:0]      best_reg, best_next;
  logic [3:0]      freq_reg, freq_next;
  logic [2*DW-1:0] peak_reg, peak_next;
  logic            done_reg, done_next;
  logic            busy_reg, busy_next;
  logic            overrun_reg, overrun_next;
  logic            capture;

  logic [2*DW-1:0]        cur_word;
  logic signed [2*DW-1:0] re_ext, im_ext;
  logic signed [2*DW-1:0] re_sq, im_sq;
  logic [2*DW-1:0]        mag;
  logic                   upd;
  logic [2*DW-1:0]        cand_max;
  logic [3:0]             cand_idx;

  assign in_words[0]  = bus.fft_d0;
  assign in_words[1]  = bus.fft_d1;
  assign in_words[2]  = bus.fft_d2;
  assign in_words[3]  = bus.fft_d3;
  assign in_words[4]  = bus.fft_d4;
  assign in_words[5]  = bus.fft_d5;
  assign in_words[6]  = bus.fft_d6;
  assign in_words[7]  = bus.fft_d7;
  assign in_words[8]  = bus.fft_d8;
  assign in_words[9]  = bus.fft_d9;
  assign in_words[10] = bus.fft_d10;
  assign in_words[11] = bus.fft_d11;
  assign in_words[12] = bus.fft_d12;
  assign in_words[13] = bus.fft_d13;
  assign in_words[14] = bus.fft_d14;
  assign in_words[15] = bus.fft_d15;

  // Squared magnitude of the bin under scan. Each square is at most 2^(2*DW-2),
  // so the unsigned sum tops out at 2^(2*DW-1) and never wraps.
  assign cur_word = bank_reg[idx_reg];
  assign re_ext   = {{DW{cur_word[2*DW-1]}}, cur_word[2*DW-1:DW]};
  assign im_ext   = {{DW{cur_word[DW-1]}},   cur_word[DW-1:0]};
  assign re_sq    = re_ext * re_ext;
  assign im_sq    = im_ext * im_ext;
  assign mag      = $unsigned(re_sq) + $unsigned(im_sq);

  // Bin 0 seeds the running max; later bins replace it only when strictly larger
  assign upd      = (idx_reg == 4'd0) || (mag > max_reg);
  assign cand_max = upd ? mag : max_reg;
  assign cand_idx = upd ? idx_reg : best_reg;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and datapath/output next values
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    max_next     = max_reg;
    best_next    = best_reg;
    freq_next    = freq_reg;
    peak_next    = peak_reg;
    done_next    = 1'b0;
    overrun_next = 1'b0;
    busy_next    = busy_reg;
    capture      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.fft_valid) begin
          capture    = 1'b1;
          idx_next   = 4'd0;
          busy_next  = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        // A frame arriving mid-scan is dropped; the scan continues untouched
        overrun_next = bus.fft_valid;
        max_next     = cand_max;
        best_next    = cand_idx;
        idx_next     = idx_reg + 4'd1;
        if (idx_reg == 4'd15) begin
          freq_next  = cand_idx;
          peak_next  = cand_max;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg     <= '0;
      max_reg     <= '0;
      best_reg    <= '0;
      freq_reg    <= '0;
      peak_reg    <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      idx_reg     <= idx_next;
      max_reg     <= max_next;
      best_reg    <= best_next;
      freq_reg    <= freq_next;
      peak_reg    <= peak_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
      overrun_reg <= overrun_next;
    end
  end

  // Capture bank: all 16 bins latched together when a frame is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) bank_reg[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < 16; i++) bank_reg[i] <= in_words[i];
    end
  end

  assign bus.done     = done_reg;
  assign bus.freq     = freq_reg;
  assign bus.peak_mag = peak_reg;
  assign bus.busy     = busy_reg;
  assign bus.overrun  = overrun_reg;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed-vector bench for fft_peak_detect with a frame-level reference model.
module tb_fft_peak_detect;

  localparam int DW = 16;

  logic clk;
  logic rst;
  logic [2*DW-1:0] frame [16];

  int n_vec = 0;
  int n_bad = 0;

  fft_peak_detect_if #(.DW(DW)) ifc ();

  fft_peak_detect #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  assign ifc.fft_d0  = frame[0];
  assign ifc.fft_d1  = frame[1];
  assign ifc.fft_d2  = frame[2];
  assign ifc.fft_d3  = frame[3];
  assign ifc.fft_d4  = frame[4];
  assign ifc.fft_d5  = frame[5];
  assign ifc.fft_d6  = frame[6];
  assign ifc.fft_d7  = frame[7];
  assign ifc.fft_d8  = frame[8];
  assign ifc.fft_d9  = frame[9];
  assign ifc.fft_d10 = frame[10];
  assign ifc.fft_d11 = frame[11];
  assign ifc.fft_d12 = frame[12];
  assign ifc.fft_d13 = frame[13];
  assign ifc.fft_d14 = frame[14];
  assign ifc.fft_d15 = frame[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: peak of the frame currently on the bus, straight from the rule
  task automatic frame_peak(output int unsigned fidx, output longint unsigned pk);
    longint best;
    longint re, im, m;
    logic [2*DW-1:0] w;
    best = -1;
    fidx = 0;
    for (int k = 0; k < 16; k++) begin
      w  = frame[k];
      re = longint'($signed(w[2*DW-1:DW]));
      im = longint'($signed(w[DW-1:0]));
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        fidx = k;
      end
    end
    pk = longint'(best);
  endtask

  // Frame-level model: an accepted frame produces its result 16 edges later
  bit              m_busy, m_done, m_ovr;
  int unsigned     m_freq, p_freq;
  longint unsigned m_peak, p_peak;
  int              m_left;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_ovr = 0; m_freq = 0; m_peak = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_ovr  = 0;
      if (m_busy) begin
        if (ifc.fft_valid) m_ovr = 1;
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_freq = p_freq; m_peak = p_peak; m_busy = 0;
        end
      end else if (ifc.fft_valid) begin
        frame_peak(p_freq, p_peak);
        m_busy = 1;
        m_left = 16;
      end
    end
    #1;
    chk("cyc_done",    ifc.done,     m_done);
    chk("cyc_busy",    ifc.busy,     m_busy);
    chk("cyc_overrun", ifc.overrun,  m_ovr);
    chk("cyc_freq",    ifc.freq,     m_freq);
    chk("cyc_peak",    ifc.peak_mag, m_peak);
  end

  task automatic set_all(input int re, input int im);
    for (int k = 0; k < 16; k++) frame[k] = {re[DW-1:0], im[DW-1:0]};
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    frame[k] = {re[DW-1:0], im[DW-1:0]};
  endtask

  // Present the current frame for exactly one rising edge; returns at the
  // falling edge after that edge
  task automatic send_frame();
    @(negedge clk);
    ifc.fft_valid = 1'b1;
    @(negedge clk);
    ifc.fft_valid = 1'b0;
  endtask

  int busy_cnt, ovr_cnt;

  task automatic wait_done(input string name, input int exp_edges,
                           input int unsigned ef, input longint unsigned ep);
    bit seen;
    int k;
    seen = 0; busy_cnt = 0; ovr_cnt = 0; k = 0;
    for (int e = 1; e <= 40 && !seen; e++) begin
      @(posedge clk); #1;
      if (ifc.busy)    busy_cnt++;
      if (ifc.overrun) ovr_cnt++;
      if (ifc.done) begin seen = 1; k = e; end
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_latency"}, k, exp_edges);
      chk({name, "_freq"}, ifc.freq, ef);
      chk({name, "_peak"}, ifc.peak_mag, ep);
      $display("frame %s: freq=%0d peak_mag=%0d after %0d edges", name, ifc.freq, ifc.peak_mag, k);
    end
  endtask

  int done_cnt;

  initial begin
    rst = 1'b0;
    ifc.fft_valid = 1'b0;
    set_all(0, 0);
    repeat (2) @(negedge clk);
    chk("rst_done", ifc.done, 0);
    chk("rst_freq", ifc.freq, 0);
    chk("rst_peak", ifc.peak_mag, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_overrun", ifc.overrun, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame: bin 5 dominates, busy spans 16 cycles
    set_all(10, 10);
    set_bin(5, 300, -400);
    send_frame();
    chk("single_busy_first", ifc.busy, 1);
    wait_done("single", 16, 5, 250000);
    chk("single_busy_cycles", busy_cnt + 1, 16);

    // Tie: equal magnitudes, lowest index wins
    set_all(0, 0);
    set_bin(3, 0, 1000);
    set_bin(12, -1000, 0);
    send_frame();
    wait_done("tie", 16, 3, 1000000);

    // Extremes: full-scale negative corner reaches 2^31 without wrapping
    set_all(32767, 0);
    set_bin(9, -32768, -32768);
    send_frame();
    wait_done("extreme", 16, 9, 64'h8000_0000);

    // All-zero frame: bin 0 wins, exactly one done
    set_all(0, 0);
    send_frame();
    wait_done("zero", 16, 0, 0);
    done_cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (ifc.done) done_cnt++; end
    chk("zero_single_done", done_cnt, 0);

    // Overrun: second frame 4 edges into the scan is dropped
    set_all(0, 0);
    set_bin(7, 100, 100);
    send_frame();
    repeat (3) @(negedge clk);
    set_all(0, 0);
    set_bin(2, 5000, 5000);
    ifc.fft_valid = 1'b1;
    @(negedge clk);
    ifc.fft_valid = 1'b0;
    chk("ovr_pulse", ifc.overrun, 1);
    wait_done("overrun", 12, 7, 20000);
    chk("ovr_once", ovr_cnt, 0);

    // Back-to-back: new frame presented in the done cycle is accepted
    set_all(1, 1);
    set_bin(14, -7, 24);
    send_frame();
    wait_done("b2b", 16, 14, 625);

    // Reset mid-scan: outputs clear at once, abandoned scan yields no done
    set_all(0, 0);
    set_bin(1, 3, 4);
    send_frame();
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_freq", ifc.freq, 0);
    chk("mid_rst_peak", ifc.peak_mag, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_done", ifc.done, 0);
    chk("mid_rst_overrun", ifc.overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (20) begin @(posedge clk); #1; if (ifc.done) done_cnt++; end
    chk("mid_rst_no_done", done_cnt, 0);

    // Normal frame after reset
    set_all(1, 0);
    set_bin(15, 0, -2);
    send_frame();
    wait_done("post_rst", 16, 15, 4);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
